// File: rtl/dmem_wait_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg_hdl;

  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_t;

  localparam int DMEM_MAX_WAIT_DEFAULT = 15;

  // Value returned by a read that hits an unimplemented address (DATA_WIDTH <= 64).
  localparam logic [63:0] DMEM_ERR_READ_VALUE = 64'h0;

  function automatic int dmem_wait_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// LC3 data-port bus between the core (master) and the memory responder (slave).
interface dmem_wait_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int WAIT_WIDTH = 4
);

  logic                  data_en;
  logic                  data_rd;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_din;
  logic [WAIT_WIDTH-1:0] cfg_wait;
  logic [DATA_WIDTH-1:0] data_dout;
  logic                  complete_data;
  logic                  data_err;
  logic                  busy;

  modport master (
    output data_en, data_rd, data_addr, data_din, cfg_wait,
    input  data_dout, complete_data, data_err, busy
  );

  modport slave (
    input  data_en, data_rd, data_addr, data_din, cfg_wait,
    output data_dout, complete_data, data_err, busy
  );

endinterface

// File: rtl/dmem_wait_responder_ram.sv
// Single-port word array with synchronous write and a registered read port whose
// output register can be cleared synchronously (reset or error read).
module dmem_ram
  import dmem_pkg_hdl::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Contents survive reset on purpose; only the output register is cleared.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else if (clr) begin
      rdata_reg <= DMEM_ERR_READ_VALUE[DATA_WIDTH-1:0];
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder: accepts one request at a time, inserts cfg_wait wait
// states, then pulses complete_data; out-of-range addresses complete with data_err.
module dmem_wait_responder
  import dmem_pkg_hdl::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int MAX_WAIT   = DMEM_MAX_WAIT_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  dmem_wait_responder_if.slave    bus
);

  localparam int WAIT_W = dmem_wait_width(MAX_WAIT);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE_W      = WAIT_W'(1);

  dmem_state_t           state_reg;
  logic [WAIT_W-1:0]     cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  rd_reg;
  logic [DATA_WIDTH-1:0] din_reg;
  logic                  complete_reg;
  logic                  err_reg;
  logic                  busy_reg;

  logic                  accept;
  logic [WAIT_W-1:0]     wait_sat;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_rd;
  logic [DATA_WIDTH-1:0] op_din;
  logic                  op_err;
  logic                  enter_resp;
  logic                  ram_we;
  logic                  ram_re;
  logic                  ram_clr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // The memory access happens on the edge entering RESP; with zero wait states
  // that is the accepting edge itself, so the operands come straight off the bus.
  always_comb begin
    accept     = bus.data_en && (state_reg == DMEM_IDLE || state_reg == DMEM_RESP);
    wait_sat   = (bus.cfg_wait > MAX_WAIT_W) ? MAX_WAIT_W : bus.cfg_wait;
    op_addr    = accept ? bus.data_addr : addr_reg;
    op_rd      = accept ? bus.data_rd   : rd_reg;
    op_din     = accept ? bus.data_din  : din_reg;
    op_err     = (op_addr >> IDX_W) != '0;
    enter_resp = (accept && wait_sat == '0) ||
                 (state_reg == DMEM_WAIT && cnt_reg == ONE_W);
    ram_we     = reset && enter_resp && !op_rd && !op_err;
    ram_re     = reset && enter_resp &&  op_rd && !op_err;
    ram_clr    = enter_resp && op_rd && op_err;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= DMEM_IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      rd_reg       <= 1'b0;
      din_reg      <= '0;
      complete_reg <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      complete_reg <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      case (state_reg)
        DMEM_IDLE, DMEM_RESP: begin
          if (accept) begin
            addr_reg <= bus.data_addr;
            rd_reg   <= bus.data_rd;
            din_reg  <= bus.data_din;
            cnt_reg  <= wait_sat;
            if (wait_sat == '0) begin
              state_reg    <= DMEM_RESP;
              complete_reg <= 1'b1;
              err_reg      <= op_err;
            end else begin
              state_reg <= DMEM_WAIT;
              busy_reg  <= 1'b1;
            end
          end else begin
            state_reg <= DMEM_IDLE;
          end
        end
        DMEM_WAIT: begin
          cnt_reg <= cnt_reg - ONE_W;
          if (cnt_reg == ONE_W) begin
            state_reg    <= DMEM_RESP;
            complete_reg <= 1'b1;
            err_reg      <= op_err;
          end else begin
            busy_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= DMEM_IDLE;
        end
      endcase
    end
  end

  dmem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .clr   (ram_clr),
    .addr  (op_addr[IDX_W-1:0]),
    .wdata (op_din),
    .rdata (ram_rdata)
  );

  assign bus.data_dout     = ram_rdata;
  assign bus.complete_data = complete_reg;
  assign bus.data_err      = err_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed self-checking bench for dmem_wait_responder; one task per scenario.
module tb_dmem_wait_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_wait_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .WAIT_WIDTH(4)) bus ();
  dmem_wait_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .WAIT_WIDTH(4)) bus_s ();

  dmem_wait_responder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .MAX_WAIT(15)
  ) u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Second instance with a non-power-of-two limit so saturation is reachable on a 4-bit port.
  dmem_wait_responder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .MAX_WAIT(10)
  ) u_sat (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                           input logic [3:0] w, output int lat, output logic [15:0] dout,
                           output logic err, output logic busy_ok);
    bus.cfg_wait  = w;
    bus.data_rd   = rd;
    bus.data_addr = addr;
    bus.data_din  = din;
    bus.data_en   = 1'b1;
    tick();
    bus.data_en = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (bus.complete_data !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (bus.complete_data !== 1'b1) lat = -1;
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    dout = bus.data_dout;
    err  = bus.data_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.complete_data !== 1'b0) begin tests_failed++; $display("FAIL reset_complete: got %b expected 0", bus.complete_data); end
    tests_run++;
    if (bus.data_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bus.data_err); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.data_dout !== 16'h0000) begin tests_failed++; $display("FAIL reset_dout: got %h expected 0000", bus.data_dout); end
    $display("[TB] reset: complete=%b err=%b busy=%b dout=%h", bus.complete_data, bus.data_err, bus.busy, bus.data_dout);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] dout;
    logic err, bok;
    do_access(1'b0, 16'h0010, 16'h1234, 4'd0, lat, dout, err, bok);
    $display("[TB] basic write @0010=1234 lat=%0d err=%b", lat, err);
    tests_run++;
    if (lat != 1) begin tests_failed++; $display("FAIL basic_wr_lat: got %0d expected 1", lat); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_wr_err: got %b expected 0", err); end
    do_access(1'b1, 16'h0010, 16'h0000, 4'd0, lat, dout, err, bok);
    $display("[TB] basic read @0010 lat=%0d dout=%h err=%b", lat, dout, err);
    tests_run++;
    if (lat != 1) begin tests_failed++; $display("FAIL basic_rd_lat: got %0d expected 1", lat); end
    tests_run++;
    if (dout !== 16'h1234) begin tests_failed++; $display("FAIL basic_rd_data: got %h expected 1234", dout); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_rd_err: got %b expected 0", err); end
    tick();
    tests_run++;
    if (bus.complete_data !== 1'b0) begin tests_failed++; $display("FAIL basic_pulse_width: got %b expected 0", bus.complete_data); end
  endtask

  task automatic test_latency();
    logic [3:0] waits [4] = '{4'd0, 4'd1, 4'd5, 4'd15};
    int exp_lat [4] = '{1, 2, 6, 16};
    int lat;
    logic [15:0] dout;
    logic err, bok;
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 16'h0010, 16'h0000, waits[i], lat, dout, err, bok);
      $display("[TB] latency cfg_wait=%0d lat=%0d busy_ok=%b dout=%h", waits[i], lat, bok, dout);
      tests_run++;
      if (lat != exp_lat[i]) begin tests_failed++; $display("FAIL latency_w%0d: got %0d expected %0d", waits[i], lat, exp_lat[i]); end
      tests_run++;
      if (bok !== 1'b1) begin tests_failed++; $display("FAIL latency_busy_w%0d: got %b expected 1", waits[i], bok); end
      tests_run++;
      if (dout !== 16'h1234) begin tests_failed++; $display("FAIL latency_data_w%0d: got %h expected 1234", waits[i], dout); end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [3:0] cfgs [4] = '{4'd13, 4'd10, 4'd9, 4'd0};
    int exp_lat [4] = '{11, 11, 10, 1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      bus_s.cfg_wait  = cfgs[i];
      bus_s.data_rd   = 1'b1;
      bus_s.data_addr = 16'h0020;
      bus_s.data_din  = 16'h0000;
      bus_s.data_en   = 1'b1;
      tick();
      bus_s.data_en = 1'b0;
      lat = 1;
      while (bus_s.complete_data !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      if (bus_s.complete_data !== 1'b1) lat = -1;
      $display("[TB] saturation MAX_WAIT=10 cfg_wait=%0d lat=%0d", cfgs[i], lat);
      tests_run++;
      if (lat != exp_lat[i]) begin tests_failed++; $display("FAIL sat_lat_c%0d: got %0d expected %0d", cfgs[i], lat, exp_lat[i]); end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [15:0] dout;
    logic err, bok;
    do_access(1'b0, 16'h0000, 16'h7777, 4'd0, lat, dout, err, bok);
    $display("[TB] oor write @0000=7777 err=%b", err);
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL oor_inrange_wr_err: got %b expected 0", err); end
    do_access(1'b0, 16'h0100, 16'hBEEF, 4'd1, lat, dout, err, bok);
    $display("[TB] oor write @0100=beef lat=%0d err=%b", lat, err);
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL oor_wr_err: got %b expected 1", err); end
    tests_run++;
    if (lat != 2) begin tests_failed++; $display("FAIL oor_wr_lat: got %0d expected 2", lat); end
    tick();
    tests_run++;
    if (bus.data_err !== 1'b0) begin tests_failed++; $display("FAIL oor_err_outside_complete: got %b expected 0", bus.data_err); end
    do_access(1'b1, 16'h0100, 16'h0000, 4'd0, lat, dout, err, bok);
    $display("[TB] oor read @0100 dout=%h err=%b", dout, err);
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_err: got %b expected 1", err); end
    tests_run++;
    if (dout !== 16'h0000) begin tests_failed++; $display("FAIL oor_rd_data: got %h expected 0000", dout); end
    do_access(1'b1, 16'hFFFF, 16'h0000, 4'd0, lat, dout, err, bok);
    $display("[TB] oor read @ffff err=%b", err);
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_top_err: got %b expected 1", err); end
    do_access(1'b1, 16'h0000, 16'h0000, 4'd0, lat, dout, err, bok);
    $display("[TB] oor read @0000 dout=%h err=%b", dout, err);
    tests_run++;
    if (dout !== 16'h7777) begin tests_failed++; $display("FAIL oor_alias_untouched: got %h expected 7777", dout); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL oor_inrange_rd_err: got %b expected 0", err); end
    tick();
  endtask

  task automatic test_back_to_back();
    int c1 = -1;
    int c2 = -1;
    int n = 0;
    logic [15:0] rd_val = 16'h0000;
    bus.cfg_wait  = 4'd2;
    bus.data_rd   = 1'b0;
    bus.data_addr = 16'h0005;
    bus.data_din  = 16'hAAAA;
    bus.data_en   = 1'b1;
    tick();
    bus.data_rd  = 1'b1;
    bus.data_din = 16'h0F0F;
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
    for (int i = 0; i < 9; i++) begin
      if (bus.complete_data === 1'b1) begin
        n++;
        if (n == 1) c1 = i;
        if (n == 2) begin
          c2 = i;
          rd_val = bus.data_dout;
          bus.data_en = 1'b0;
        end
      end
      tick();
    end
    bus.data_en = 1'b0;
    $display("[TB] back_to_back completions=%0d at %0d,%0d read=%h", n, c1, c2, rd_val);
    tests_run++;
    if (c1 != 2) begin tests_failed++; $display("FAIL b2b_first: got %0d expected 2", c1); end
    tests_run++;
    if (c2 != 5) begin tests_failed++; $display("FAIL b2b_second: got %0d expected 5", c2); end
    tests_run++;
    if (n != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", n); end
    tests_run++;
    if (rd_val !== 16'hAAAA) begin tests_failed++; $display("FAIL b2b_read_data: got %h expected aaaa", rd_val); end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [15:0] dout;
    logic err, bok;
    logic seen = 1'b0;
    do_access(1'b0, 16'h0007, 16'h1111, 4'd0, lat, dout, err, bok);
    tick();
    bus.cfg_wait  = 4'd4;
    bus.data_rd   = 1'b0;
    bus.data_addr = 16'h0007;
    bus.data_din  = 16'h5555;
    bus.data_en   = 1'b1;
    tick();
    bus.data_en = 1'b0;
    tick();
    rst_n = 1'b0;
    bus.data_en = 1'b1;
    bus.data_rd = 1'b1;
    tick();
    $display("[TB] reset mid-write: complete=%b busy=%b err=%b dout=%h", bus.complete_data, bus.busy, bus.data_err, bus.data_dout);
    tests_run++;
    if (bus.complete_data !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_complete: got %b expected 0", bus.complete_data); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.data_dout !== 16'h0000) begin tests_failed++; $display("FAIL rst_mid_dout: got %h expected 0000", bus.data_dout); end
    rst_n = 1'b1;
    bus.data_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.complete_data === 1'b1) seen = 1'b1;
      tick();
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_complete: got %b expected 0", seen); end
    do_access(1'b1, 16'h0007, 16'h0000, 4'd0, lat, dout, err, bok);
    $display("[TB] read @0007 after aborted write dout=%h", dout);
    tests_run++;
    if (dout !== 16'h1111) begin tests_failed++; $display("FAIL rst_mid_not_committed: got %h expected 1111", dout); end
    tick();
  endtask

  task automatic test_cfg_change();
    int lat;
    logic [15:0] dout;
    logic err, bok;
    bus.cfg_wait  = 4'd3;
    bus.data_rd   = 1'b1;
    bus.data_addr = 16'h0005;
    bus.data_en   = 1'b1;
    tick();
    bus.data_en  = 1'b0;
    bus.cfg_wait = 4'd0;
    lat = 1;
    while (bus.complete_data !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (bus.complete_data !== 1'b1) lat = -1;
    dout = bus.data_dout;
    $display("[TB] cfg change in flight lat=%0d dout=%h", lat, dout);
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL cfgchg_lat: got %0d expected 4", lat); end
    tests_run++;
    if (dout !== 16'hAAAA) begin tests_failed++; $display("FAIL cfgchg_data: got %h expected aaaa", dout); end
    tick();
    do_access(1'b1, 16'h0005, 16'h0000, 4'd0, lat, dout, err, bok);
    $display("[TB] next request with cfg_wait=0 lat=%0d", lat);
    tests_run++;
    if (lat != 1) begin tests_failed++; $display("FAIL cfgchg_next_lat: got %0d expected 1", lat); end
    tick();
  endtask

  initial begin
    bus.data_en = 1'b0;   bus.data_rd = 1'b0;   bus.data_addr = '0;
    bus.data_din = '0;    bus.cfg_wait = '0;
    bus_s.data_en = 1'b0; bus_s.data_rd = 1'b0; bus_s.data_addr = '0;
    bus_s.data_din = '0;  bus_s.cfg_wait = '0;
    test_reset();
    test_basic();
    test_latency();
    test_saturation();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_write();
    test_cfg_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
